// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit BCD display among three requesters.
// Each owner keeps the display for a minimum dwell; invalid BCD digits are blanked to 0.
module disp_arbiter #(
  parameter int unsigned DWELL_CYC = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        active,
  output logic        bcd_err
);

  localparam logic [26:0] CntMax = 27'(DWELL_CYC - 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [26:0]       cnt_q, cnt_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic              err_q, err_d;

  logic [2:0]        others, load_sel;
  logic              owner_req, load_en, new_owner;
  logic [15:0]       load_word;

  // First requester found searching from p, p+1, p+2 (mod 3); one-hot result.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] g;
    logic [2:0] sum;
    logic [1:0] idx;
    g = '0;
    for (int unsigned i = 3; i > 0; i--) begin
      sum = {1'b0, p} + 3'(i - 1);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (r[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [2:0] g);
    logic [1:0] p;
    case (g)
      3'b001:  p = 2'd1;
      3'b010:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    err_d     = err_q;
    load_sel  = '0;
    load_en   = 1'b0;
    new_owner = 1'b0;
    load_word = '0;
    others    = req & ~grant_q;
    owner_req = |(req & grant_q);

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          new_owner = 1'b1;
          load_sel  = rr_pick(req, ptr_q);
        end
      end
      StHold: begin
        if ((!owner_req || (cnt_q == CntMax)) && (|others)) begin
          new_owner = 1'b1;
          load_sel  = rr_pick(others, ptr_q);
        end else if (!owner_req) begin
          state_d = StIdle;
          grant_d = '0;
        end else begin
          load_en  = 1'b1;
          load_sel = grant_q;
          cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 27'd1;
        end
      end
      default: ;
    endcase

    if (new_owner) begin
      state_d = StHold;
      grant_d = load_sel;
      ptr_d   = ptr_after(load_sel);
      cnt_d   = '0;
      load_en = 1'b1;
    end

    if (load_en) begin
      case (load_sel)
        3'b001:  load_word = data0;
        3'b010:  load_word = data1;
        3'b100:  load_word = data2;
        default: load_word = '0;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (load_word[4*i +: 4] > 4'd9) begin
          dig_d[i] = '0;
          err_d    = 1'b1;
        end else begin
          dig_d[i] = load_word[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
    end
  end

  assign grant   = grant_q;
  assign active  = |grant_q;
  assign digit0  = dig_q[0];
  assign digit1  = dig_q[1];
  assign digit2  = dig_q[2];
  assign digit3  = dig_q[3];
  assign bcd_err = err_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_disp_arbiter;

  localparam int Dwell = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [15:0] data0 = '0, data1 = '0, data2 = '0;
  logic [2:0]  grant;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        active, bcd_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          m_owner;
  int          m_ptr;
  int          m_cnt;
  logic [15:0] m_digits;
  logic        m_err;

  disp_arbiter #(.DWELL_CYC(Dwell)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data0  (data0),
    .data1  (data1),
    .data2  (data2),
    .grant  (grant),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .active (active),
    .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dut_digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit has(input logic [2:0] r, input int k);
    return r[2'(k)];
  endfunction

  function automatic int pick(input logic [2:0] r, input int p);
    for (int i = 0; i < 3; i++) if (has(r, (p + i) % 3)) return (p + i) % 3;
    return -1;
  endfunction

  function automatic logic [15:0] word_of(input int k);
    return (k == 0) ? data0 : (k == 1) ? data1 : data2;
  endfunction

  task automatic model_load(input int k);
    logic [15:0] w;
    int nib;
    w = word_of(k);
    for (int d = 0; d < 4; d++) begin
      nib = int'((w >> (4 * d)) & 16'hF);
      if (nib > 9) begin
        nib = 0;
        m_err = 1'b1;
      end
      m_digits[4*d +: 4] = 4'(nib);
    end
  endtask

  task automatic model_grant(input int k);
    m_owner = k;
    m_ptr   = (k + 1) % 3;
    m_cnt   = 0;
    model_load(k);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_digits = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] others;
    if (m_owner < 0) begin
      if (req != 0) model_grant(pick(req, m_ptr));
    end else begin
      others = req & ~(3'(1) << m_owner);
      if (!has(req, m_owner)) begin
        if (others != 0) model_grant(pick(others, m_ptr));
        else m_owner = -1;
      end else if (m_cnt == Dwell - 1 && others != 0) begin
        model_grant(pick(others, m_ptr));
      end else begin
        model_load(m_owner);
        if (m_cnt < Dwell - 1) m_cnt++;
      end
    end
  endtask

  task automatic chk_model(input string name);
    logic [2:0] g;
    g = (m_owner < 0) ? 3'b000 : 3'(1) << m_owner;
    chk(name, 32'({grant, active, bcd_err, dut_digits()}),
        32'({g, (m_owner >= 0), m_err, m_digits}));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({grant, active, bcd_err, dut_digits()}), 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(0, 9);
      if ($urandom_range(0, 49) == 0) d = $urandom_range(10, 15);
      w[4*i +: 4] = 4'(d);
    end
    return w;
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  grant;
    logic [15:0] digits;
  } vec_t;

  vec_t vecs[17];

  initial begin
    model_reset();
    // Dwell and rotation table: req=011 throughout.
    for (int i = 0; i < 17; i++) begin
      vecs[i].req = 3'b011;
      if (i < 8) begin
        vecs[i].grant = 3'b001; vecs[i].digits = 16'h1234;
      end else if (i < 16) begin
        vecs[i].grant = 3'b010; vecs[i].digits = 16'h5678;
      end else begin
        vecs[i].grant = 3'b001; vecs[i].digits = 16'h1234;
      end
    end

    // Single request
    do_reset();
    req = 3'b001; data0 = 16'h1234;
    step();
    chk("single_grant", 32'(grant), 32'(3'b001));
    chk("single_active", 32'(active), 32'd1);
    chk("single_digits", 32'(dut_digits()), 32'h1234);

    // Dwell and rotation
    do_reset();
    data0 = 16'h1234; data1 = 16'h5678; data2 = 16'h9999;
    for (int i = 0; i < 17; i++) begin
      req = vecs[i].req;
      step();
      chk($sformatf("rot_grant[%0d]", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("rot_digits[%0d]", i), 32'(dut_digits()), 32'(vecs[i].digits));
    end

    // Early release, cnt restart, then idle freeze
    do_reset();
    data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;
    req = 3'b101;
    repeat (3) step();
    chk("early_owner0", 32'(grant), 32'(3'b001));
    req = 3'b100;
    step();
    chk("early_switch", 32'({grant, dut_digits()}), 32'({3'b100, 16'h3333}));
    req = 3'b110;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("early_hold[%0d]", i), 32'(grant), 32'(3'b100));
    end
    step();
    chk("early_next", 32'({grant, dut_digits()}), 32'({3'b010, 16'h2222}));
    req = 3'b000;
    step();
    chk("idle_drop", 32'({grant, active, dut_digits()}), 32'({3'b000, 1'b0, 16'h2222}));
    data1 = 16'h4444;
    step();
    chk("idle_frozen", 32'(dut_digits()), 32'h2222);

    // Invalid BCD, sticky error
    do_reset();
    req = 3'b001; data0 = 16'h12A4;
    step();
    chk("bcd_digits", 32'(dut_digits()), 32'h1204);
    chk("bcd_err_set", 32'(bcd_err), 32'd1);
    data0 = 16'h1234;
    step();
    chk("bcd_fixed", 32'({bcd_err, dut_digits()}), 32'({1'b1, 16'h1234}));
    req = 3'b000;
    step();
    chk("bcd_sticky", 32'(bcd_err), 32'd1);

    // Asynchronous reset mid-HOLD
    do_reset();
    req = 3'b001; data0 = 16'h5678;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({grant, active, bcd_err, dut_digits()}), 32'h0);
    rst = 1'b0;
    model_reset();
    req = 3'b111;
    step();
    chk("rst_resume", 32'(grant), 32'(3'b001));

    // Live update and non-owner isolation
    do_reset();
    req = 3'b011;
    data0 = 16'h0000;
    step();
    for (int i = 0; i < 6; i++) begin
      data0 = rand_bcd() & 16'h7777;
      data1 = $urandom();
      data2 = $urandom();
      step();
      chk($sformatf("live[%0d]", i), 32'(dut_digits()), 32'(data0));
    end
    data1 = ~data1; data2 = ~data2;
    step();
    chk("isolate", 32'(dut_digits()), 32'(data0));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) data0 = rand_bcd();
      if ($urandom_range(0, 1) == 0) data1 = rand_bcd();
      if ($urandom_range(0, 1) == 0) data2 = rand_bcd();
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
      chk_model($sformatf("rand[%0d]", c));
      chk("onehot", 32'($countones(grant) <= 1 && active == |grant), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
